piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in serial-out transmitter. It accepts WIDTH-bit words on a valid/ready handshake and emits them one bit per clock, with framing strobes. It is the transmit-side counterpart to the util shift/delay-line blocks and is used to drive serial links, DAC/shift-chip chains and test pattern lanes.
A one-word holding register allows gap-free back-to-back words.

Parameters:
WIDTH, 8, word width in bits; must be >= 2.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
GAP, 0, number of idle cycles (sdout_vld=0) inserted between consecutive words; 0..255.

Ports:
clk  in  1  single clock; all logic on posedge.
rst  in  1  synchronous reset, active-low; reset is applied when rst==0 at a posedge.
din  in  WIDTH  parallel word.
din_vld  in  1  din valid.
din_rdy  out  1  holding register empty; transfer occurs when din_vld & din_rdy at posedge.
sdout  out  1  serial data bit.
sdout_vld  out  1  sdout carries a valid bit.
sfirst  out  1  first bit of word (qualified by sdout_vld).
slast  out  1  last bit of word (qualified by sdout_vld).
busy  out  1  word in shifter, or GAP countdown active.

Behaviour:
- Reset (rst==0 at posedge):
  - state<=IDLE; hold_full<=0; bit_cnt<=0; gap_cnt<=0.
  - sdout, sdout_vld, sfirst, slast, busy all <=0.
  - din_rdy is forced 0 while rst==0. It reads 1 from the first cycle after reset is released.
  - Reset mid-word discards the shifter and the holding word with no partial flush.
- All outputs except din_rdy are registered. din_rdy = rst & ~hold_full.
- Accept: din_vld & din_rdy at edge Ea -> hold<=din, hold_full<=1. din is not sampled otherwise. din_vld held while din_rdy=0 must not lose or duplicate data.
- States:
  - IDLE: if hold_full, load shifter from hold, clear hold_full, bit_cnt<=0, go SHIFT.
  - SHIFT:
    - Each cycle, present the next bit: sdout_vld=1; sfirst=(bit_cnt==0); slast=(bit_cnt==WIDTH-1).
    - At the edge ending the slast cycle:
      - GAP>0 -> GAP, gap_cnt<=GAP-1.
      - GAP==0 and hold_full -> reload shifter, stay in SHIFT (no bubble).
      - Otherwise -> IDLE.
  - GAP: sdout_vld=0, sdout=0. gap_cnt decrements each cycle. When gap_cnt==0:
    - hold_full -> load, go SHIFT.
    - Otherwise -> IDLE.
- Latency: word accepted at Ea in IDLE is loaded at Ea+1. Its first bit is valid in the cycle after Ea+1. Each word occupies exactly WIDTH valid cycles.
- Simultaneous accept + load in the same edge: hold takes the new din, hold_full stays 1, and the shifter takes the old hold. No word loss.
- Throughput with GAP=0 and continuous din_vld: one word per WIDTH cycles, sdout_vld stuck high.
- Bit order: MSB_FIRST shifts left and emits shifter[WIDTH-1]; otherwise shifts right and emits shifter[0].
- Counter widths: bit_cnt is clog2(WIDTH) bits, gap_cnt is 8 bits. No wrap beyond WIDTH-1.
- sdout=0 whenever sdout_vld=0.

Decomposition:
- Shared util package/include holds:
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_GAP=2'd2;
  - the clog2 constant function.
- No sub-module. Counters, shifter and holding register stay inline. This is a single-level block of roughly 150-250 lines.

Test Plan:
1. Reset behaviour: hold rst=0 for 3 cycles with din_vld=1 -> din_rdy=0, all outputs 0; release -> din_rdy=1 the next cycle.
2. Single word, WIDTH=8, MSB_FIRST=1, din=8'hA5 -> sdout 1,0,1,0,0,1,0,1 on 8 consecutive vld cycles; sfirst on bit 1, slast on bit 8; first bit two cycles after the accept edge.
3. Back-to-back words, GAP=0: 8'hA5 then 8'h3C with din_vld held -> 16 consecutive vld cycles, pattern A5 then 3C, sfirst at cycles 1 and 9, no bubble.
4. GAP=2, MSB_FIRST=0, words 8'h01 and 8'h80 -> 1,0,0,0,0,0,0,0, two cycles with vld=0, then 0,0,0,0,0,0,0,1.
5. Backpressure: present 3 words with din_vld always 1 -> din_rdy drops while hold is full; exactly 3 words are serialized in order, with none lost or repeated.
6. Reset mid-word: assert rst=0 during bit 4 of 8'hFF with a second word held -> the next cycle has sdout_vld=0; after release, no residual bits are emitted and busy=0.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// ---------------------------------------------------------------------------
// piso_serializer_pkg
// Shared definitions for the parallel-in serial-out transmitter:
//   - state_t  : FSM state encodings (IDLE / SHIFT / GAP)
//   - clog2    : constant function used to size the bit counter
// ---------------------------------------------------------------------------
package piso_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Ceiling log2 for elaboration-time sizing; callers pass value >= 2.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
// Parallel-in serial-out transmitter. Words arrive on a valid/ready handshake
// into a one-word holding register and are shifted out one bit per clock
// with first/last framing strobes. The holding register lets the next word
// wait while the current one is shifting, so words can run back to back.
//
// Ports:
//   clk       in   clock, all logic on posedge
//   rst       in   synchronous reset, active low
//   din       in   [WIDTH-1:0] parallel word
//   din_vld   in   din valid
//   din_rdy   out  holding register empty (forced 0 while in reset)
//   sdout     out  serial data bit (0 whenever sdout_vld is 0)
//   sdout_vld out  sdout carries a valid bit
//   sfirst    out  first bit of a word (qualified by sdout_vld)
//   slast     out  last bit of a word (qualified by sdout_vld)
//   busy      out  word in shifter or inter-word gap countdown active
// ---------------------------------------------------------------------------
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  output logic             din_rdy,
  output logic             sdout,
  output logic             sdout_vld,
  output logic             sfirst,
  output logic             slast,
  output logic             busy
);

  localparam int             CW       = clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);
  localparam logic [7:0]     GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] hold_reg;
  logic             hold_full_reg, hold_full_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]       gap_cnt_reg, gap_cnt_next;
  logic             load;
  logic             accept;

  logic sdout_reg, sdout_vld_reg, sfirst_reg, slast_reg, busy_reg;
  logic sdout_next, sdout_vld_next, sfirst_next, slast_next, busy_next;

  assign din_rdy = rst & ~hold_full_reg;
  assign accept  = din_vld & din_rdy;

  // Holding register data: only written on a handshake, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_reg <= din;
    end
  end

  // State register, counters, shifter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      hold_full_reg <= 1'b0;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      gap_cnt_reg   <= '0;
      sdout_reg     <= 1'b0;
      sdout_vld_reg <= 1'b0;
      sfirst_reg    <= 1'b0;
      slast_reg     <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_full_reg <= hold_full_next;
      shift_reg     <= shift_next;
      bit_cnt_reg   <= bit_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      sdout_reg     <= sdout_next;
      sdout_vld_reg <= sdout_vld_next;
      sfirst_reg    <= sfirst_next;
      slast_reg     <= slast_next;
      busy_reg      <= busy_next;
    end
  end

  // Next-state logic. In SHIFT, bit_cnt_reg indexes the bit currently on
  // sdout and the shifter keeps that bit at its output end.
  always_comb begin
    state_next   = state_reg;
    load         = 1'b0;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (hold_full_reg) begin
          load       = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_reg == LAST_IDX) begin
          if (GAP > 0) begin
            state_next   = ST_GAP;
            gap_cnt_next = GAP_LOAD;
          end else if (hold_full_reg) begin
            load = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg + CW'(1);
          shift_next   = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_reg == 8'd0) begin
          if (hold_full_reg) begin
            load       = 1'b1;
            state_next = ST_SHIFT;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg - 8'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (load) begin
      shift_next   = hold_reg;
      bit_cnt_next = '0;
    end

    // A new accept keeps the register full even when the old word is
    // being moved into the shifter on the same edge.
    hold_full_next = accept | (hold_full_reg & ~load);
  end

  // Output logic: computed from next-state values so the registered
  // strobes line up with the cycle in which the shifter holds that bit.
  always_comb begin
    sdout_vld_next = (state_next == ST_SHIFT);
    sdout_next     = sdout_vld_next &
                     (MSB_FIRST ? shift_next[WIDTH-1] : shift_next[0]);
    sfirst_next    = sdout_vld_next & (bit_cnt_next == '0);
    slast_next     = sdout_vld_next & (bit_cnt_next == LAST_IDX);
    busy_next      = (state_next != ST_IDLE);
  end

  assign sdout     = sdout_reg;
  assign sdout_vld = sdout_vld_reg;
  assign sfirst    = sfirst_reg;
  assign slast     = slast_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
// Two instances: dut_a (MSB first, no gap) and dut_b (LSB first, GAP=2).
// Accepted words are expanded into an expected bit stream; the observed
// stream (with the cycle of each valid bit) is compared against it.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

  localparam int W     = 8;
  localparam int GAP_B = 2;

  typedef struct packed {
    logic bit_v;
    logic first;
    logic last;
  } sbit_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din_a, din_b;
  logic         din_vld_a, din_vld_b;
  logic         din_rdy_a, din_rdy_b;
  logic         sdout_a, sdout_vld_a, sfirst_a, slast_a, busy_a;
  logic         sdout_b, sdout_vld_b, sfirst_b, slast_b, busy_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit checking = 1'b0;
  int stalls   = 0;

  sbit_t exp_a[$], exp_b[$], obs_a[$], obs_b[$];
  int    cyc_a[$], cyc_b[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP(0)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_vld(din_vld_a), .din_rdy(din_rdy_a),
    .sdout(sdout_a), .sdout_vld(sdout_vld_a), .sfirst(sfirst_a), .slast(slast_a),
    .busy(busy_a)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP(GAP_B)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .din_vld(din_vld_b), .din_rdy(din_rdy_b),
    .sdout(sdout_b), .sdout_vld(sdout_vld_b), .sfirst(sfirst_b), .slast(slast_b),
    .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model: every accepted word becomes W serial bits in link order.
  always @(posedge clk) begin
    if (rst && din_vld_a && din_rdy_a) begin
      for (int k = 0; k < W; k++)
        exp_a.push_back('{bit_v: din_a[W-1-k], first: (k == 0), last: (k == W-1)});
    end
    if (rst && din_vld_b && din_rdy_b) begin
      for (int k = 0; k < W; k++)
        exp_b.push_back('{bit_v: din_b[k], first: (k == 0), last: (k == W-1)});
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    cyc++;
    if (sdout_vld_a === 1'b1) begin
      obs_a.push_back('{bit_v: sdout_a, first: sfirst_a, last: slast_a});
      cyc_a.push_back(cyc);
    end else if (checking) begin
      chk("a sdout idle zero", {31'd0, sdout_a}, 32'd0);
    end
    if (sdout_vld_b === 1'b1) begin
      obs_b.push_back('{bit_v: sdout_b, first: sfirst_b, last: slast_b});
      cyc_b.push_back(cyc);
    end else if (checking) begin
      chk("b sdout idle zero", {31'd0, sdout_b}, 32'd0);
    end
  end

  task automatic send_a(input logic [W-1:0] w);
    int n = 0;
    din_a = w;
    din_vld_a = 1'b1;
    while (din_rdy_a !== 1'b1 && n < 200) begin
      stalls++;
      @(negedge clk);
      n++;
    end
    chk("a send timeout", {31'd0, n >= 200}, 32'd0);
    @(posedge clk);
    $display("[tb] dut_a accepted word %02h", w);
    @(negedge clk);
  endtask

  task automatic send_b(input logic [W-1:0] w);
    int n = 0;
    din_b = w;
    din_vld_b = 1'b1;
    while (din_rdy_b !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b send timeout", {31'd0, n >= 200}, 32'd0);
    @(posedge clk);
    $display("[tb] dut_b accepted word %02h", w);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((busy_a || busy_b || obs_a.size() != exp_a.size() ||
            obs_b.size() != exp_b.size()) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain timeout", {31'd0, n >= 300}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Compares streams; between words the spacing must be gap+1 (exact) or
  // at least gap+1 (when the next word may have arrived late).
  task automatic compare(input string tag, input sbit_t e[$], input sbit_t o[$],
                         input int c[$], input int gap, input bit exact);
    chk({tag, " count"}, o.size(), e.size());
    for (int i = 0; i < o.size() && i < e.size(); i++)
      chk({tag, " bit"}, {29'd0, o[i]}, {29'd0, e[i]});
    for (int i = 1; i < o.size(); i++) begin
      if (o[i].first) begin
        if (exact) chk({tag, " word spacing"}, c[i] - c[i-1], gap + 1);
        else       chk({tag, " word spacing min"}, {31'd0, (c[i] - c[i-1]) >= gap + 1}, 32'd1);
      end else begin
        chk({tag, " bit spacing"}, c[i] - c[i-1], 1);
      end
    end
    $display("[tb] %s: %0d bits compared", tag, o.size());
  endtask

  task automatic clear_all();
    exp_a.delete(); obs_a.delete(); cyc_a.delete();
    exp_b.delete(); obs_b.delete(); cyc_b.delete();
  endtask

  initial begin
    logic [W-1:0] pat;
    int n;

    // ---- 1: reset with din_vld asserted ----
    rst = 1'b0;
    din_a = 8'h55; din_b = 8'h55;
    din_vld_a = 1'b1; din_vld_b = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset din_rdy_a", {31'd0, din_rdy_a}, 32'd0);
      chk("reset din_rdy_b", {31'd0, din_rdy_b}, 32'd0);
      chk("reset outs a", {27'd0, sdout_a, sdout_vld_a, sfirst_a, slast_a, busy_a}, 32'd0);
      chk("reset outs b", {27'd0, sdout_b, sdout_vld_b, sfirst_b, slast_b, busy_b}, 32'd0);
    end
    rst = 1'b1;
    din_vld_a = 1'b0; din_vld_b = 1'b0;
    checking = 1'b1;
    @(negedge clk);
    chk("post reset din_rdy_a", {31'd0, din_rdy_a}, 32'd1);
    chk("post reset din_rdy_b", {31'd0, din_rdy_b}, 32'd1);
    chk("post reset busy_a", {31'd0, busy_a}, 32'd0);
    $display("[tb] reset sequence done");

    // ---- 2: single word A5, cycle-exact timing ----
    pat = 8'b1010_0101;
    din_a = 8'hA5;
    din_vld_a = 1'b1;
    @(negedge clk);               // accept edge has passed
    din_vld_a = 1'b0;
    #1;
    chk("single vld after accept", {31'd0, sdout_vld_a}, 32'd0);
    chk("single hold full", {31'd0, din_rdy_a}, 32'd0);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      #1;
      chk("single vld", {31'd0, sdout_vld_a}, 32'd1);
      chk("single bit", {31'd0, sdout_a}, {31'd0, pat[W-1-k]});
      chk("single sfirst", {31'd0, sfirst_a}, {31'd0, k == 0});
      chk("single slast", {31'd0, slast_a}, {31'd0, k == W-1});
    end
    @(negedge clk);
    #1;
    chk("single vld end", {31'd0, sdout_vld_a}, 32'd0);
    chk("single busy end", {31'd0, busy_a}, 32'd0);
    drain();
    compare("single", exp_a, obs_a, cyc_a, 0, 1'b1);
    clear_all();

    // ---- 3: back-to-back, GAP=0 ----
    send_a(8'hA5);
    send_a(8'h3C);
    din_vld_a = 1'b0;
    drain();
    chk("b2b length", obs_a.size(), 16);
    if (obs_a.size() == 16) begin
      chk("b2b span", cyc_a[15] - cyc_a[0], 15);
      chk("b2b sfirst 9", {31'd0, obs_a[8].first}, 32'd1);
    end
    compare("b2b", exp_a, obs_a, cyc_a, 0, 1'b1);
    clear_all();

    // ---- 4: GAP=2, LSB first, 01 then 80 ----
    send_b(8'h01);
    send_b(8'h80);
    din_vld_b = 1'b0;
    drain();
    chk("gap length", obs_b.size(), 16);
    if (obs_b.size() == 16) begin
      chk("gap idle cycles", cyc_b[8] - cyc_b[7], GAP_B + 1);
      chk("gap word0 bit0", {31'd0, obs_b[0].bit_v}, 32'd1);
      chk("gap word1 bit7", {31'd0, obs_b[15].bit_v}, 32'd1);
    end
    compare("gap", exp_b, obs_b, cyc_b, GAP_B, 1'b1);
    clear_all();

    // ---- 5: backpressure with din_vld held ----
    stalls = 0;
    send_a(W'($urandom));
    send_a(W'($urandom));
    send_a(W'($urandom));
    din_vld_a = 1'b0;
    chk("backpressure seen", {31'd0, stalls > 0}, 32'd1);
    drain();
    chk("backpressure length", obs_a.size(), 3 * W);
    compare("backpressure", exp_a, obs_a, cyc_a, 0, 1'b1);
    clear_all();

    // ---- 6: reset mid-word with a second word held ----
    send_a(8'hFF);
    send_a(8'h5A);
    din_vld_a = 1'b0;
    n = 0;
    while (obs_a.size() < 4 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("midreset wait timeout", {31'd0, n >= 50}, 32'd0);
    chk("midreset hold full", {31'd0, din_rdy_a}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("midreset vld", {31'd0, sdout_vld_a}, 32'd0);
    chk("midreset busy", {31'd0, busy_a}, 32'd0);
    chk("midreset din_rdy", {31'd0, din_rdy_a}, 32'd0);
    rst = 1'b1;
    clear_all();
    repeat (20) @(negedge clk);
    #1;
    chk("midreset residual bits", obs_a.size(), 0);
    chk("midreset busy after", {31'd0, busy_a}, 32'd0);
    chk("midreset din_rdy after", {31'd0, din_rdy_a}, 32'd1);
    $display("[tb] mid-word reset done");
    clear_all();

    // ---- 7: randomized traffic on both instances ----
    repeat (400) begin
      @(negedge clk);
      din_vld_a = ($urandom_range(0, 3) != 0);
      din_a     = W'($urandom);
      din_vld_b = ($urandom_range(0, 2) == 0);
      din_b     = W'($urandom);
    end
    @(negedge clk);
    din_vld_a = 1'b0;
    din_vld_b = 1'b0;
    drain();
    compare("random a", exp_a, obs_a, cyc_a, 0, 1'b0);
    compare("random b", exp_b, obs_b, cyc_b, GAP_B, 1'b0);
    clear_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
